// File: rtl/div_new_pkg.sv
// rtl/div_new_pkg.sv - shared width, step count and FSM state type for the restoring divider
package div_new_pkg;
    localparam int DIV_WIDTH = 5;
    localparam int DIV_STEPS = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] partial,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remainder,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // partial < divisor always holds, so shifted < 2*divisor and trial[WIDTH] is a clean borrow flag
    assign shifted   = {partial, dividend_bit};
    assign trial     = shifted - {1'b0, divisor};
    assign q_bit     = ~trial[WIDTH];
    assign remainder = q_bit ? trial[WIDTH-1:0] : {partial[WIDTH-2:0], dividend_bit};
endmodule

// File: rtl/div_new.sv
// rtl/div_new.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module div_new
    import div_new_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] reminder,
    output logic             error
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] part_rem;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial     (part_rem),
        .dividend_bit(dividend[WIDTH-1]),
        .divisor     (divisor),
        .remainder   (step_rem),
        .q_bit       (step_q)
    );

    // Dividend bits leave at the MSB while quotient bits enter at the LSB
    assign q_next = {dividend[WIDTH-2:0], step_q};

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= IDLE;
            dividend <= '0;
            divisor  <= '0;
            part_rem <= '0;
            cnt      <= '0;
            quotient <= '0;
            reminder <= '0;
            error    <= 1'b0;
        end else if (load) begin
            dividend <= A;
            divisor  <= B;
            part_rem <= '0;
            cnt      <= '0;
            state    <= LOAD;
        end else begin
            case (state)
                LOAD, CALC: begin
                    if (state == LOAD && divisor == '0) begin
                        quotient <= '1;
                        reminder <= dividend;
                        error    <= 1'b1;
                        state    <= DONE;
                    end else begin
                        part_rem <= step_rem;
                        dividend <= q_next;
                        cnt      <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            quotient <= q_next;
                            reminder <= step_rem;
                            error    <= 1'b0;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_div_new.sv
// tb/tb_div_new.sv - randomized scoreboard bench for div_new
module tb_div_new;
    import div_new_pkg::*;

    localparam int W = 5;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] reminder;
    logic         error;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;

    // transaction-level model state
    int   m_a, m_b, m_low;
    bit   m_busy = 0;
    int   m_q = 0, m_r = 0;
    bit   m_e = 0;

    div_new #(.WIDTH(W)) dut (
        .clk     (clk),
        .res     (res),
        .load    (load),
        .A       (A),
        .B       (B),
        .quotient(quotient),
        .reminder(reminder),
        .error   (error)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic l, input int a, input int b);
        exp_t x;
        @(negedge clk);
        res  = r;
        load = l;
        A    = W'(a);
        B    = W'(b);
        @(posedge clk);
        cycle++;
        if (r) begin
            m_q = 0; m_r = 0; m_e = 0; m_busy = 0;
        end else if (l) begin
            m_a = a; m_b = b; m_low = 0; m_busy = 1;
        end else if (m_busy) begin
            m_low++;
            if (m_b == 0) begin
                m_q = (1 << W) - 1; m_r = m_a; m_e = 1; m_busy = 0;
            end else if (m_low == DIV_STEPS) begin
                m_q = m_a / m_b; m_r = m_a % m_b; m_e = 0; m_busy = 0;
            end
        end
        x.q = W'(m_q);
        x.r = W'(m_r);
        x.e = m_e;
        x.tag = cycle;
        exp_q.push_back(x);
    endtask

    task automatic divide(input int a, input int b, input int hold, input int low);
        for (int i = 0; i < hold; i++) cyc(1'b0, 1'b1, a, b);
        for (int i = 0; i < low; i++) cyc(1'b0, 1'b0, $urandom_range(0, 31), $urandom_range(0, 31));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            if (quotient !== x.q || reminder !== x.r || error !== x.e) begin
                errors++;
                $display("FAIL outputs edge %0d: got q=%0d r=%0d e=%0b, expected q=%0d r=%0d e=%0b",
                         x.tag, quotient, reminder, error, x.q, x.r, x.e);
            end
        end
    end

    initial begin
        cyc(1'b1, 1'b0, 0, 0);
        divide(29, 14, 5, 5);
        divide(10, 26, 1, 5);
        divide(0, 26, 1, 5);
        divide(21, 0, 1, 2);
        divide(0, 0, 1, 2);
        divide(21, 13, 1, 5);
        divide(29, 3, 1, 6);
        divide(29, 3, 1, 2);
        divide(29, 14, 1, 3);
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 7, 2);
        divide(31, 1, 2, 5);
        divide(31, 31, 1, 5);

        for (int n = 0; n < 200; n++) begin
            int a, b, hold, low;
            a    = $urandom_range(0, 31);
            b    = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31);
            hold = $urandom_range(1, 3);
            low  = $urandom_range(0, 7);
            for (int i = 0; i < hold; i++) begin
                if (i > 0 && $urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, 31);
                    b = $urandom_range(0, 31);
                end
                cyc(1'b0, 1'b1, a, b);
            end
            for (int i = 0; i < low; i++)
                cyc($urandom_range(0, 24) == 0, $urandom_range(0, 40) == 0, a, b);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_new.md
DIV_NEW -- requirements
Module: div_new

Interface
REQ-001 Parameter WIDTH, default 5, operand/result width in bits; all values below assume WIDTH=5.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 res  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 load  input  1  operand-load control: 1 = capture operands, 0 = divide.
REQ-005 A  input  WIDTH  dividend, unsigned.
REQ-006 B  input  WIDTH  divisor, unsigned.
REQ-007 quotient  output  WIDTH  registered quotient of last completed division.
REQ-008 reminder  output  WIDTH  registered remainder of last completed division.
REQ-009 error  output  1  registered divide-by-zero flag for the last captured operand pair.

Function
REQ-010 The block SHALL perform unsigned restoring division, one quotient bit per clock, MSB first.
REQ-011 FSM states SHALL be IDLE, LOAD, CALC, DONE.
REQ-012 In any state, a rising edge with load=1 SHALL capture A and B, clear the step counter, clear the partial remainder, and enter LOAD.
REQ-013 load=1 held for several cycles SHALL re-capture A and B every cycle; the last captured pair is used.
REQ-014 In LOAD with load=0 and B!=0, the block SHALL enter CALC and execute step 1 on that edge.
REQ-015 CALC SHALL execute one step per edge while load=0: shift partial remainder left by one, insert the next dividend bit, subtract B if the result is >= B, and set the quotient bit.
REQ-016 After step WIDTH (5th load-low edge), quotient/reminder SHALL be updated with the final values, error=0, and the FSM SHALL enter DONE.
REQ-017 DONE SHALL hold quotient, reminder and error until the next capture; IDLE behaves identically.
REQ-018 quotient/reminder SHALL NOT change during LOAD or CALC; they show the previous result until completion.
REQ-019 If the captured B=0, the first load-low edge SHALL set error=1, quotient=all ones (5'b11111), reminder=A, and enter DONE without iterating.
REQ-020 A=0 with B!=0 SHALL complete normally with quotient=0 and reminder=0.
REQ-021 A<B SHALL yield quotient=0 and reminder=A.
REQ-022 load reasserted mid-CALC SHALL abort the division; outputs keep the previous result.
REQ-023 Internal arithmetic SHALL use WIDTH+1 bits for the trial subtraction, so no overflow can occur.

Reset
REQ-024 res=1 on a rising edge SHALL force IDLE, quotient=0, reminder=0, error=0, and clear the counter and working registers.
REQ-025 res SHALL take priority over load.
REQ-026 Reset mid-CALC SHALL discard the division in progress.

Structure
REQ-027 A shared package SHALL hold the WIDTH default, the FSM state enum typedef and the step-count constant (WIDTH).
REQ-028 One sub-module, div_step, SHALL implement a single combinational restoring iteration: inputs partial remainder, dividend bit and divisor; outputs new remainder and quotient bit.
REQ-029 div_new SHALL contain the FSM, operand/working registers, counter and output registers.

Verification
REQ-030 res pulse, then load=1 for 5 cycles with A=29, B=14, then load=0 for 5 cycles -> quotient=2, reminder=1, error=0 after the 5th low edge.
REQ-031 A=10, B=26 -> quotient=0, reminder=10; A=0, B=26 -> quotient=0, reminder=0.
REQ-032 A=21, B=0 -> error=1, quotient=31, reminder=21 one edge after load falls; then A=0, B=0 -> same error behaviour with reminder=0.
REQ-033 A=21, B=13 -> quotient=1, reminder=8; A=29, B=3 -> quotient=9, reminder=2; error returns to 0.
REQ-034 Start A=29, B=3, assert load after 2 calc cycles -> outputs unchanged; reassert res mid-CALC -> all outputs 0 next edge.
